lstm_gate_mac: RTL and testbench

- Serial multiply-accumulate stage that computes one LSTM gate pre-activation: sum over k of (x_k * w_k), plus bias.
- Sits directly upstream of the tanh/sigmoid activation units and drives their input word.
- Uses the same signed 24-bit Q8.16 fixed-point format as the activations: 1.0 = 0x010000.
- Accepts one x/w pair per cycle under a valid/ready handshake and emits one saturated 24-bit result per vector.

---
 rtl/lstm_gate_mac_pkg.sv | 16 +
 rtl/lstm_gate_mac_if.sv | 24 ++
 rtl/lstm_gate_mac_fxp_mul_shift.sv | 15 +
 rtl/lstm_gate_mac.sv | 87 ++++++++
 tb/tb_lstm_gate_mac.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/lstm_gate_mac_pkg.sv
// rtl/lstm_gate_mac_pkg.sv - shared Q8.16 fixed-point constants and MAC state encoding
package lstm_gate_mac_pkg;

    localparam int WIDTH = 24;
    localparam int FRAC  = 16;

    localparam logic [WIDTH-1:0] ONE     = 24'h010000;
    localparam logic [WIDTH-1:0] MAX_POS = 24'h7FFFFF;
    localparam logic [WIDTH-1:0] MAX_NEG = 24'h800000;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/lstm_gate_mac_if.sv
// rtl/lstm_gate_mac_if.sv - term/result handshake bundle for the gate MAC
interface lstm_gate_mac_if #(
    parameter int WIDTH = lstm_gate_mac_pkg::WIDTH
);
    logic             i_start;
    logic [WIDTH-1:0] i_bias;
    logic             i_valid;
    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_w;
    logic             o_ready;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;

    modport master (
        output i_start, i_bias, i_valid, i_x, i_w,
        input  o_ready, o_busy, o_valid, o_data
    );

    modport slave (
        input  i_start, i_bias, i_valid, i_x, i_w,
        output o_ready, o_busy, o_valid, o_data
    );
endinterface

// File: rtl/lstm_gate_mac_fxp_mul_shift.sv
// rtl/lstm_gate_mac_fxp_mul_shift.sv - signed fixed-point multiply rescaled by FRAC (floor)
module fxp_mul_shift #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 16
) (
    input  logic signed [WIDTH-1:0]          a,
    input  logic signed [WIDTH-1:0]          b,
    output logic signed [2*WIDTH-FRAC-1:0]   p
);
    logic signed [2*WIDTH-1:0] full;

    assign full = a * b;
    // Arithmetic shift floors toward -inf; the dropped top bits are pure sign copies.
    assign p = (2*WIDTH-FRAC)'(full >>> FRAC);
endmodule

// File: rtl/lstm_gate_mac.sv
// rtl/lstm_gate_mac.sv - serial dot-product plus bias feeding the LSTM activation units
module lstm_gate_mac #(
    parameter int WIDTH     = lstm_gate_mac_pkg::WIDTH,
    parameter int FRAC      = lstm_gate_mac_pkg::FRAC,
    parameter int N_IN      = 4,
    parameter int ACC_WIDTH = 40
) (
    input  logic            clk,
    input  logic            rst_n,
    lstm_gate_mac_if.slave  bus
);
    import lstm_gate_mac_pkg::*;

    localparam int PW = 2*WIDTH - FRAC;
    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t                        state;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic [CW-1:0]                 cnt;
    logic signed [PW-1:0]          term;
    logic [WIDTH-1:0]              sat_data;
    logic                          valid_q;
    logic [WIDTH-1:0]              data_q;

    fxp_mul_shift #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mul (
        .a (signed'(bus.i_x)),
        .b (signed'(bus.i_w)),
        .p (term)
    );

    assign acc_next = acc + ACC_WIDTH'(term);

    // Clip only at the output; the accumulator is wide enough never to wrap.
    always_comb begin
        sat_data = acc_next[WIDTH-1:0];
        if (acc_next > SAT_HI)
            sat_data = SAT_HI[WIDTH-1:0];
        else if (acc_next < SAT_LO)
            sat_data = SAT_LO[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        acc   <= ACC_WIDTH'(signed'(bus.i_bias));
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (bus.i_valid) begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(N_IN-1)) begin
                            data_q  <= sat_data;
                            valid_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready = (state == ACC);
    assign bus.o_busy  = (state != IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
endmodule

// File: tb/tb_lstm_gate_mac.sv
// tb/tb_lstm_gate_mac.sv - randomized self-checking bench for lstm_gate_mac
module tb_lstm_gate_mac;
    import lstm_gate_mac_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;
    int   nvec = 0;

    lstm_gate_mac_if #(.WIDTH(24)) bus ();

    lstm_gate_mac #(
        .WIDTH(24), .FRAC(16), .N_IN(4), .ACC_WIDTH(40)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.o_valid) pulses++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [23:0] b,
                                          input logic [23:0] xs[4],
                                          input logic [23:0] ws[4]);
        longint s;
        longint p;
        s = longint'($signed(b));
        for (int k = 0; k < 4; k++) begin
            p = longint'($signed(xs[k])) * longint'($signed(ws[k]));
            s += p >>> 16;
        end
        if (s > 64'sd8388607) s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
        return s[23:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [23:0] b,
                           input logic [23:0] xs[4], input logic [23:0] ws[4],
                           input bit gappy);
        logic [23:0] exp;
        exp = model(b, xs, ws);
        check({tag, "_idle"}, bus.o_busy, 0);
        bus.i_start = 1'b1;
        bus.i_bias  = b;
        bus.i_valid = gappy;
        bus.i_x     = 24'($urandom);
        bus.i_w     = 24'($urandom);
        tick();
        check({tag, "_started"}, {bus.o_busy, bus.o_ready, bus.o_valid}, 3'b110);
        bus.i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (gappy) begin
                int g;
                g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    bus.i_valid = 1'b0;
                    bus.i_start = 1'($urandom_range(0, 1));
                    bus.i_x     = 24'($urandom);
                    tick();
                end
                check({tag, "_stall_ready"}, bus.o_ready, 1);
                bus.i_start = 1'b0;
            end
            bus.i_valid = 1'b1;
            bus.i_x     = xs[k];
            bus.i_w     = ws[k];
            tick();
            if (k < 3) check({tag, "_no_early_valid"}, bus.o_valid, 0);
        end
        bus.i_valid = 1'b0;
        nvec++;
        check({tag, "_valid"}, bus.o_valid, 1);
        check({tag, "_busy_drop"}, bus.o_busy, 0);
        check({tag, "_data"}, bus.o_data, exp);
    endtask

    initial begin
        logic [23:0] xs[4];
        logic [23:0] ws[4];
        bus.i_start = 1'b0;
        bus.i_bias  = '0;
        bus.i_valid = 1'b0;
        bus.i_x     = '0;
        bus.i_w     = '0;
        repeat (3) tick();
        check("rst_state", {bus.o_busy, bus.o_ready, bus.o_valid}, 3'b000);
        check("rst_data", bus.o_data, 0);
        rst_n = 1'b1;
        tick();

        xs = '{ONE, ONE, ONE, ONE};
        ws = '{24'h008000, 24'h008000, 24'h008000, 24'h008000};
        run_vec("basic", 24'h0, xs, ws, 0);
        check("basic_const", bus.o_data, 24'h020000);
        tick();
        check("basic_pulse_end", bus.o_valid, 0);

        xs = '{24'hFF0000, 24'h020000, 24'h0, 24'h0};
        ws = '{24'h010000, 24'h020000, 24'h123456, 24'hABCDEF};
        run_vec("signs", 24'h008000, xs, ws, 0);
        check("signs_const", bus.o_data, 24'h038000);

        xs = '{24'h000001, 24'hFFFFFF, 24'h0, 24'h0};
        ws = '{24'h008000, 24'h008000, 24'h0, 24'h0};
        run_vec("floor", 24'h0, xs, ws, 0);
        check("floor_const", bus.o_data, 24'hFFFFFF);

        xs = '{24'h100000, 24'h0, 24'h0, 24'h0};
        ws = '{24'h100000, 24'h0, 24'h0, 24'h0};
        run_vec("sat_pos", 24'h7F0000, xs, ws, 0);
        check("sat_pos_const", bus.o_data, MAX_POS);
        ws[0] = 24'hF00000;
        run_vec("sat_neg", 24'h7F0000, xs, ws, 0);
        check("sat_neg_const", bus.o_data, MAX_NEG);

        // stray valid while idle must not disturb anything
        tick();
        bus.i_valid = 1'b1;
        bus.i_x = 24'h7FFFFF;
        bus.i_w = 24'h7FFFFF;
        repeat (3) tick();
        bus.i_valid = 1'b0;
        check("idle_valid_ignored", {bus.o_busy, bus.o_valid}, 2'b00);

        for (int n = 0; n < 20; n++) begin
            logic [23:0] b;
            for (int k = 0; k < 4; k++) begin
                if (n % 2) begin
                    xs[k] = 24'($urandom);
                    ws[k] = 24'($urandom);
                end else begin
                    xs[k] = 24'($signed($urandom_range(0, 24'h3FFFF)) - 24'sh20000);
                    ws[k] = 24'($signed($urandom_range(0, 24'h3FFFF)) - 24'sh20000);
                end
            end
            b = 24'($urandom);
            run_vec("rand", b, xs, ws, 1);
            if (n % 3 == 0) tick();
        end

        // abort after two accepted terms
        xs = '{24'h050000, 24'h030000, 24'h010000, 24'h020000};
        ws = '{24'h010000, 24'h010000, 24'h010000, 24'h010000};
        tick();
        bus.i_start = 1'b1;
        bus.i_bias  = 24'h010000;
        tick();
        bus.i_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.i_valid = 1'b1;
            bus.i_x = xs[k];
            bus.i_w = ws[k];
            tick();
        end
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_state", {bus.o_busy, bus.o_ready, bus.o_valid}, 3'b000);
        check("abort_data", bus.o_data, 0);
        tick();
        check("abort_no_valid", bus.o_valid, 0);
        xs = '{24'h010000, 24'h010000, 24'h0, 24'h0};
        run_vec("post_abort", 24'h0, xs, ws, 0);
        check("post_abort_const", bus.o_data, 24'h020000);
        tick();
        tick();
        check("pulse_count", pulses, nvec);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
